bucket_writeback_unit: RTL and testbench
========================================

Name: bucket_writeback_unit

Overview:
- Write side of the per-table read-modify-write pipeline. Takes one operation per cycle plus the corrected bucket that has already been read for it, and modifies that bucket.
- Supported operations: insert, update, delete, lookup.
- Drives the table memory write port, and drives the forward_* bundle that the forwarding logic compares against newer reads.
- Keeps a per-table occupancy count. One instance per hash table.

Parameters:
- DATA_WIDTH, 4, data bits per entry
- KEY_WIDTH, 2, key bits per entry
- BUCKET_SIZE, 2, entries (slots) per bucket
- MAX_HASH_ADR_WIDTH, 2, bucket address width
- OCC_WIDTH, MAX_HASH_ADR_WIDTH+$clog2(BUCKET_SIZE+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- clk_en  in  1  global pipeline enable; all registers hold when 0
- op_valid_i  in  1  operation present this cycle
- op_i  in  2  0=NOP, 1=INSERT, 2=DELETE, 3=LOOKUP
- key_i  in  KEY_WIDTH  operation key
- data_i  in  DATA_WIDTH  insert data
- hash_adr_i  in  MAX_HASH_ADR_WIDTH  bucket address
- content_i  in  (KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE  corrected bucket contents
- valid_i  in  BUCKET_SIZE  corrected per-slot valid bits
- mem_we_o  out  1  memory write enable
- mem_adr_o  out  MAX_HASH_ADR_WIDTH  write address
- mem_content_o  out  (KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE  write data
- mem_valid_o  out  BUCKET_SIZE  write valid bits
- forward_hash_adr_o  out  MAX_HASH_ADR_WIDTH  to forwarder
- forward_content_o  out  (KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE  to forwarder
- forward_updated_mem_o  out  1  to forwarder; equals mem_we_o
- forward_valid_o  out  BUCKET_SIZE  to forwarder
- result_valid_o  out  1  result strobe
- result_status_o  out  2  0=OK, 1=UPDATED, 2=FULL, 3=NOT_FOUND
- result_data_o  out  DATA_WIDTH  lookup data; 0 otherwise
- occupancy_o  out  OCC_WIDTH  valid entries in the table

Behaviour:
- Bucket packing:
  - Slot s occupies bits [(s+1)*E-1 : s*E], where E = KEY_WIDTH+DATA_WIDTH.
  - Within a slot, the key sits in the MSBs and the data in the LSBs.
- Slot selection:
  - Match = valid_i[s] and key equal; the lowest-index match wins.
  - Free = lowest s with valid_i[s]=0.
- Latency and enable:
  - Inputs are sampled on a rising edge with clk_en=1.
  - All outputs are registered and appear 1 cycle later.
  - With clk_en=0 every register, including the occupancy counter, holds its value.
- Output values by case (NOP or op_valid_i=0 means: mem_we_o=0, result_valid_o=0):
  - INSERT, match present:
    - Overwrite the match slot's data; key and valid bits unchanged.
    - mem_we_o=1, status UPDATED, occupancy unchanged.
  - INSERT, no match, free slot present:
    - Write key/data into the free slot and set its valid bit.
    - mem_we_o=1, status OK, occupancy +1.
  - INSERT, no match, no free slot: mem_we_o=0, status FULL.
  - DELETE, match present:
    - Clear the match slot's valid bit; slot content is left as is.
    - mem_we_o=1, status OK, occupancy -1.
  - DELETE, no match: mem_we_o=0, status NOT_FOUND.
  - LOOKUP:
    - mem_we_o=0 always.
    - Match: status OK, result_data_o = match slot data.
    - No match: status NOT_FOUND.
- Memory and forward outputs:
  - mem_adr_o/forward_hash_adr_o = sampled hash_adr_i, every valid op.
  - mem_content_o/forward_content_o and mem_valid_o/forward_valid_o carry the modified bucket when writing, else the unmodified input bucket.
  - forward_updated_mem_o equals mem_we_o in every cycle.
- Result and counter:
  - result_valid_o=1 for one enabled cycle per non-NOP valid op.
  - Occupancy counter saturates at all-ones and at 0; it never wraps.
- Reset:
  - All outputs and the counter go to 0 immediately.
  - An operation in flight is dropped: no write and no result.

Decomposition:
- Shared package hash_pkg:
  - op_e enum (NOP/INSERT/DELETE/LOOKUP)
  - status_e enum (OK/UPDATED/FULL/NOT_FOUND)
  - slot-slicing helper functions
- Sub-module bucket_slot_search, combinational:
  - Inputs: key, bucket, valid bits.
  - Outputs: match_found, match_idx, free_found, free_idx.
  - Reusable by the lookup path.

Test Plan:
- Reset, then INSERT key=01 data=A adr=1, content=0, valid=00:
  - Next cycle mem_we_o=1, mem_adr_o=1, mem_content_o[5:0]=011010, mem_valid_o=01.
  - forward_updated_mem_o=1, status OK, occupancy 1.
- INSERT key=01 data=7 with slot0 = key 01 data 3, valid=01:
  - mem_content_o[3:0]=7, mem_valid_o=01, status UPDATED, occupancy unchanged.
- INSERT key=01 with valid=11, keys 00 and 10:
  - mem_we_o=0, forward_updated_mem_o=0, status FULL, occupancy unchanged.
- DELETE key=10 with valid=11 (slot1 key 10):
  - mem_valid_o=01, status OK, occupancy -1.
- DELETE key=11 (no match): mem_we_o=0, status NOT_FOUND.
- LOOKUP key=00, slot0 data=5: result_data_o=5, status OK, mem_we_o=0.
- Issue an INSERT, then hold clk_en=0 for 3 cycles:
  - All outputs frozen throughout.
- Assert reset mid-INSERT:
  - All outputs 0 asynchronously.
  - After release, no result for the dropped op.

Source files
------------

// File: rtl/hash_pkg.sv
// -----------------------------------------------------------------------------
// hash_pkg
// Shared types and helpers for the hash-table pipeline.
//   - Default geometry of one hash table (entry/bucket/address widths).
//   - op_e     : operation codes carried on op_i.
//   - status_e : result codes driven on result_status_o.
//   - slot_lsb / key_lsb : bit offsets of a slot and of its key inside a
//     packed bucket. A slot is {key, data} with the key in the MSBs, and slot s
//     starts at bit s*(KEY_WIDTH+DATA_WIDTH).
// -----------------------------------------------------------------------------
package hash_pkg;

  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_KEY_WIDTH   = 2;
  localparam int DEF_BUCKET_SIZE = 2;
  localparam int DEF_ADR_WIDTH   = 2;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_LOOKUP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_UPDATED   = 2'd1,
    ST_FULL      = 2'd2,
    ST_NOT_FOUND = 2'd3
  } status_e;

  // Lowest bit of slot 'slot' (also the lowest bit of its data field).
  function automatic int slot_lsb(input int slot, input int entry_width);
    return slot * entry_width;
  endfunction

  // Lowest bit of the key field of slot 'slot'.
  function automatic int key_lsb(input int slot, input int key_width, input int data_width);
    return slot * (key_width + data_width) + data_width;
  endfunction

endpackage : hash_pkg

// File: rtl/bucket_slot_search.sv
// -----------------------------------------------------------------------------
// bucket_slot_search
// Purely combinational search of one bucket for a key.
//   key          in   KEY_WIDTH                 key to look for
//   bucket       in   (KEY+DATA)*BUCKET_SIZE    packed bucket contents
//   valid        in   BUCKET_SIZE               per-slot valid bits
//   match_found  out  1                         some valid slot holds key
//   match_idx    out  IDX_WIDTH                 lowest matching slot
//   free_found   out  1                         some slot is invalid
//   free_idx     out  IDX_WIDTH                 lowest invalid slot
// -----------------------------------------------------------------------------
module bucket_slot_search
  import hash_pkg::*;
#(
  parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BUCKET_SIZE = DEF_BUCKET_SIZE,
  parameter int IDX_WIDTH   = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
  input  logic [KEY_WIDTH-1:0]                          key,
  input  logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0] bucket,
  input  logic [BUCKET_SIZE-1:0]                        valid,
  output logic                                          match_found,
  output logic [IDX_WIDTH-1:0]                          match_idx,
  output logic                                          free_found,
  output logic [IDX_WIDTH-1:0]                          free_idx
);

  localparam int ENTRY_WIDTH = KEY_WIDTH + DATA_WIDTH;

  // NOTE: every output gets a default before the loop; a path that leaves
  // a combinational output unassigned would infer a latch.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    // Scan from the top slot down so the lowest index is the last writer.
    for (int s = BUCKET_SIZE - 1; s >= 0; s--) begin
      if (valid[s] && (bucket[key_lsb(s, KEY_WIDTH, DATA_WIDTH) +: KEY_WIDTH] == key)) begin
        match_found = 1'b1;
        match_idx   = IDX_WIDTH'(s);
      end
      if (!valid[s]) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(s);
      end
    end
  end

  // Data fields take no part in the search.
  logic [DATA_WIDTH*BUCKET_SIZE-1:0] data_bits;
  for (genvar g = 0; g < BUCKET_SIZE; g++) begin : g_data
    assign data_bits[g*DATA_WIDTH +: DATA_WIDTH] = bucket[slot_lsb(g, ENTRY_WIDTH) +: DATA_WIDTH];
  end
  logic unused_data;
  assign unused_data = ^data_bits;

endmodule : bucket_slot_search

// File: rtl/bucket_writeback_unit.sv
// -----------------------------------------------------------------------------
// bucket_writeback_unit
// Write side of one hash table's read-modify-write pipeline. Each enabled cycle
// it takes one operation plus the already-corrected bucket read for it,
// applies INSERT / DELETE / LOOKUP, and one cycle later drives the memory write
// port, the forwarding bundle and a result. Keeps the table's occupancy count.
//   clk, reset (async, active low), clk_en (global hold when 0)
//   op_valid_i, op_i, key_i, data_i, hash_adr_i   operation
//   content_i, valid_i                            corrected bucket
//   mem_*_o                                       table write port
//   forward_*_o                                   copy for newer reads
//   result_valid_o, result_status_o, result_data_o
//   occupancy_o                                   saturating entry count
// -----------------------------------------------------------------------------
module bucket_writeback_unit
  import hash_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int KEY_WIDTH          = DEF_KEY_WIDTH,
  parameter int BUCKET_SIZE        = DEF_BUCKET_SIZE,
  parameter int MAX_HASH_ADR_WIDTH = DEF_ADR_WIDTH,
  parameter int OCC_WIDTH          = MAX_HASH_ADR_WIDTH + $clog2(BUCKET_SIZE + 1)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clk_en,
  input  logic                                          op_valid_i,
  input  logic [1:0]                                    op_i,
  input  logic [KEY_WIDTH-1:0]                          key_i,
  input  logic [DATA_WIDTH-1:0]                         data_i,
  input  logic [MAX_HASH_ADR_WIDTH-1:0]                 hash_adr_i,
  input  logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0] content_i,
  input  logic [BUCKET_SIZE-1:0]                        valid_i,
  output logic                                          mem_we_o,
  output logic [MAX_HASH_ADR_WIDTH-1:0]                 mem_adr_o,
  output logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0] mem_content_o,
  output logic [BUCKET_SIZE-1:0]                        mem_valid_o,
  output logic [MAX_HASH_ADR_WIDTH-1:0]                 forward_hash_adr_o,
  output logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0] forward_content_o,
  output logic                                          forward_updated_mem_o,
  output logic [BUCKET_SIZE-1:0]                        forward_valid_o,
  output logic                                          result_valid_o,
  output logic [1:0]                                    result_status_o,
  output logic [DATA_WIDTH-1:0]                         result_data_o,
  output logic [OCC_WIDTH-1:0]                          occupancy_o
);

  localparam int ENTRY_WIDTH  = KEY_WIDTH + DATA_WIDTH;
  localparam int BUCKET_WIDTH = ENTRY_WIDTH * BUCKET_SIZE;
  localparam int IDX_WIDTH    = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;

  // ---------------------------------------------------------------------------
  // Slot search on the incoming bucket
  // ---------------------------------------------------------------------------
  logic                 match_found;
  logic [IDX_WIDTH-1:0] match_idx;
  logic                 free_found;
  logic [IDX_WIDTH-1:0] free_idx;

  bucket_slot_search #(
    .KEY_WIDTH  (KEY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BUCKET_SIZE(BUCKET_SIZE),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_search (
    .key        (key_i),
    .bucket     (content_i),
    .valid      (valid_i),
    .match_found(match_found),
    .match_idx  (match_idx),
    .free_found (free_found),
    .free_idx   (free_idx)
  );

  // ---------------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------------
  logic                    nxt_we;
  logic [BUCKET_WIDTH-1:0] nxt_content;
  logic [BUCKET_SIZE-1:0]  nxt_valid;
  logic                    nxt_result_valid;
  status_e                 nxt_status;
  logic [DATA_WIDTH-1:0]   nxt_data;
  logic                    occ_inc;
  logic                    occ_dec;

  always_comb begin
    // Unless a write happens the input bucket passes through unmodified.
    nxt_we           = 1'b0;
    nxt_content      = content_i;
    nxt_valid        = valid_i;
    nxt_result_valid = 1'b0;
    nxt_status       = ST_OK;
    nxt_data         = '0;
    occ_inc          = 1'b0;
    occ_dec          = 1'b0;

    if (op_valid_i) begin
      unique case (op_e'(op_i))
        OP_INSERT: begin
          nxt_result_valid = 1'b1;
          if (match_found) begin
            nxt_content[slot_lsb(int'(match_idx), ENTRY_WIDTH) +: DATA_WIDTH] = data_i;
            nxt_we     = 1'b1;
            nxt_status = ST_UPDATED;
          end else if (free_found) begin
            nxt_content[slot_lsb(int'(free_idx), ENTRY_WIDTH) +: ENTRY_WIDTH] = {key_i, data_i};
            nxt_valid[free_idx] = 1'b1;
            nxt_we     = 1'b1;
            occ_inc    = 1'b1;
          end else begin
            nxt_status = ST_FULL;
          end
        end
        OP_DELETE: begin
          nxt_result_valid = 1'b1;
          if (match_found) begin
            // Only the valid bit is cleared; stale key/data stay in memory.
            nxt_valid[match_idx] = 1'b0;
            nxt_we     = 1'b1;
            occ_dec    = 1'b1;
          end else begin
            nxt_status = ST_NOT_FOUND;
          end
        end
        OP_LOOKUP: begin
          nxt_result_valid = 1'b1;
          if (match_found) begin
            nxt_data = content_i[slot_lsb(int'(match_idx), ENTRY_WIDTH) +: DATA_WIDTH];
          end else begin
            nxt_status = ST_NOT_FOUND;
          end
        end
        default: ;  // OP_NOP
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output and counter registers
  // ---------------------------------------------------------------------------
  logic                          we_q;
  logic [MAX_HASH_ADR_WIDTH-1:0] adr_q;
  logic [BUCKET_WIDTH-1:0]       content_q;
  logic [BUCKET_SIZE-1:0]        valid_q;
  logic                          result_valid_q;
  status_e                       status_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic [OCC_WIDTH-1:0]          occ_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q           <= 1'b0;
      adr_q          <= '0;
      content_q      <= '0;
      valid_q        <= '0;
      result_valid_q <= 1'b0;
      status_q       <= ST_OK;
      data_q         <= '0;
      occ_q          <= '0;
    end else if (clk_en) begin
      we_q           <= nxt_we;
      adr_q          <= hash_adr_i;
      content_q      <= nxt_content;
      valid_q        <= nxt_valid;
      result_valid_q <= nxt_result_valid;
      status_q       <= nxt_status;
      data_q         <= nxt_data;
      // Saturating count: stick at all-ones and at zero instead of wrapping.
      if (occ_inc && (occ_q != '1)) begin
        occ_q <= occ_q + 1'b1;
      end else if (occ_dec && (occ_q != '0)) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign mem_we_o              = we_q;
  assign mem_adr_o             = adr_q;
  assign mem_content_o         = content_q;
  assign mem_valid_o           = valid_q;
  assign forward_hash_adr_o    = adr_q;
  assign forward_content_o     = content_q;
  assign forward_updated_mem_o = we_q;
  assign forward_valid_o       = valid_q;
  assign result_valid_o        = result_valid_q;
  assign result_status_o       = status_q;
  assign result_data_o         = data_q;
  assign occupancy_o           = occ_q;

endmodule : bucket_writeback_unit

// File: tb/tb_bucket_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_bucket_writeback_unit
// Self-checking bench for bucket_writeback_unit with default geometry
// (KEY 2, DATA 4, 2 slots per bucket, 2-bit address, 4-bit occupancy).
// Inputs change on the falling edge; outputs are read on the next falling edge.
// -----------------------------------------------------------------------------
module tb_bucket_writeback_unit;

  localparam int OCC_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        op_valid_i;
  logic [1:0]  op_i;
  logic [1:0]  key_i;
  logic [3:0]  data_i;
  logic [1:0]  hash_adr_i;
  logic [11:0] content_i;
  logic [1:0]  valid_i;
  logic        mem_we_o;
  logic [1:0]  mem_adr_o;
  logic [11:0] mem_content_o;
  logic [1:0]  mem_valid_o;
  logic [1:0]  forward_hash_adr_o;
  logic [11:0] forward_content_o;
  logic        forward_updated_mem_o;
  logic [1:0]  forward_valid_o;
  logic        result_valid_o;
  logic [1:0]  result_status_o;
  logic [3:0]  result_data_o;
  logic [3:0]  occupancy_o;

  always #5 clk = ~clk;

  bucket_writeback_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .clk_en               (clk_en),
    .op_valid_i           (op_valid_i),
    .op_i                 (op_i),
    .key_i                (key_i),
    .data_i               (data_i),
    .hash_adr_i           (hash_adr_i),
    .content_i            (content_i),
    .valid_i              (valid_i),
    .mem_we_o             (mem_we_o),
    .mem_adr_o            (mem_adr_o),
    .mem_content_o        (mem_content_o),
    .mem_valid_o          (mem_valid_o),
    .forward_hash_adr_o   (forward_hash_adr_o),
    .forward_content_o    (forward_content_o),
    .forward_updated_mem_o(forward_updated_mem_o),
    .forward_valid_o      (forward_valid_o),
    .result_valid_o       (result_valid_o),
    .result_status_o      (result_status_o),
    .result_data_o        (result_data_o),
    .occupancy_o          (occupancy_o)
  );

  int checks   = 0;
  int failures = 0;
  int occ_m    = 0;

  typedef struct {
    logic        we;
    logic        rv;
    logic [1:0]  st;
    logic [11:0] content;
    logic [1:0]  valid;
    logic [3:0]  rdata;
    int          occ_delta;
  } exp_t;

  typedef struct {
    logic        ov;
    logic [1:0]  op;
    logic [1:0]  key;
    logic [3:0]  data;
    logic [1:0]  adr;
    logic [11:0] content;
    logic [1:0]  valid;
    exp_t        e;
    int          occ;
  } vector_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference behaviour: unpack the bucket into slot records, apply the
  // operation's rules, repack.
  function automatic exp_t model(input logic ov, input logic [1:0] op, input logic [1:0] key,
                                 input logic [3:0] data, input logic [11:0] content,
                                 input logic [1:0] valid);
    exp_t       e;
    logic [1:0] k [2];
    logic [3:0] d [2];
    logic [1:0] v;
    int         m;
    int         f;
    for (int s = 0; s < 2; s++) begin
      d[s] = content[s*6 +: 4];
      k[s] = content[s*6+4 +: 2];
    end
    v = valid;
    m = -1;
    f = -1;
    for (int s = 0; s < 2; s++) begin
      if (m < 0 && v[s] && k[s] == key) m = s;
      if (f < 0 && !v[s]) f = s;
    end
    e = '{we: 1'b0, rv: 1'b0, st: 2'd0, content: content, valid: valid, rdata: 4'd0, occ_delta: 0};
    if (ov && op != 2'd0) begin
      e.rv = 1'b1;
      case (op)
        2'd1: begin
          if (m >= 0) begin
            d[m] = data; e.we = 1'b1; e.st = 2'd1;
          end else if (f >= 0) begin
            k[f] = key; d[f] = data; v[f] = 1'b1; e.we = 1'b1; e.occ_delta = 1;
          end else begin
            e.st = 2'd2;
          end
        end
        2'd2: begin
          if (m >= 0) begin
            v[m] = 1'b0; e.we = 1'b1; e.occ_delta = -1;
          end else begin
            e.st = 2'd3;
          end
        end
        default: begin
          if (m >= 0) e.rdata = d[m];
          else        e.st = 2'd3;
        end
      endcase
      if (e.we) begin
        e.content = {k[1], d[1], k[0], d[0]};
        e.valid   = v;
      end
    end
    return e;
  endfunction

  function automatic int clamp_occ(input int v);
    if (v < 0) return 0;
    if (v > OCC_MAX) return OCC_MAX;
    return v;
  endfunction

  task automatic apply(input logic ov, input logic [1:0] op, input logic [1:0] key,
                       input logic [3:0] data, input logic [1:0] adr,
                       input logic [11:0] content, input logic [1:0] valid);
    op_valid_i = ov;
    op_i       = op;
    key_i      = key;
    data_i     = data;
    hash_adr_i = adr;
    content_i  = content;
    valid_i    = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input exp_t e, input logic chk_adr,
                           input logic [1:0] adr, input int occ);
    check($sformatf("%s.mem_we", tag), 32'(mem_we_o), 32'(e.we));
    check($sformatf("%s.fwd_updated", tag), 32'(forward_updated_mem_o), 32'(e.we));
    check($sformatf("%s.result_valid", tag), 32'(result_valid_o), 32'(e.rv));
    check($sformatf("%s.mem_content", tag), 32'(mem_content_o), 32'(e.content));
    check($sformatf("%s.fwd_content", tag), 32'(forward_content_o), 32'(e.content));
    check($sformatf("%s.mem_valid", tag), 32'(mem_valid_o), 32'(e.valid));
    check($sformatf("%s.fwd_valid", tag), 32'(forward_valid_o), 32'(e.valid));
    check($sformatf("%s.result_data", tag), 32'(result_data_o), 32'(e.rdata));
    check($sformatf("%s.occupancy", tag), 32'(occupancy_o), 32'(occ));
    if (e.rv) check($sformatf("%s.status", tag), 32'(result_status_o), 32'(e.st));
    if (chk_adr) begin
      check($sformatf("%s.mem_adr", tag), 32'(mem_adr_o), 32'(adr));
      check($sformatf("%s.fwd_adr", tag), 32'(forward_hash_adr_o), 32'(adr));
    end
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z = '{we: 1'b0, rv: 1'b0, st: 2'd0, content: 12'h000, valid: 2'b00, rdata: 4'd0, occ_delta: 0};
    check_all(tag, z, 1'b1, 2'd0, 0);
    check($sformatf("%s.status", tag), 32'(result_status_o), 32'd0);
  endtask

  function automatic vector_t mkv(input logic ov, input logic [1:0] op, input logic [1:0] key,
                                  input logic [3:0] data, input logic [1:0] adr,
                                  input logic [11:0] content, input logic [1:0] valid,
                                  input logic we, input logic rv, input logic [1:0] st,
                                  input logic [11:0] econt, input logic [1:0] evalid,
                                  input logic [3:0] rdata, input int occ);
    vector_t t;
    t.ov = ov; t.op = op; t.key = key; t.data = data; t.adr = adr;
    t.content = content; t.valid = valid;
    t.e = '{we: we, rv: rv, st: st, content: econt, valid: evalid, rdata: rdata, occ_delta: 0};
    t.occ = occ;
    return t;
  endfunction

  vector_t vec[13];

  initial begin
    exp_t e;
    exp_t frozen;

    //           ov  op    key    data   adr    content  valid   we  rv  st     econt    evalid rdata occ
    vec[0]  = mkv(1, 2'd1, 2'b01, 4'hA, 2'd1, 12'h000, 2'b00,   1,  1, 2'd0, 12'h01A, 2'b01, 4'h0, 1);
    vec[1]  = mkv(1, 2'd1, 2'b01, 4'h7, 2'd2, 12'h013, 2'b01,   1,  1, 2'd1, 12'h017, 2'b01, 4'h0, 1);
    vec[2]  = mkv(1, 2'd1, 2'b01, 4'h9, 2'd3, 12'h881, 2'b11,   0,  1, 2'd2, 12'h881, 2'b11, 4'h0, 1);
    vec[3]  = mkv(1, 2'd2, 2'b10, 4'h0, 2'd3, 12'h881, 2'b11,   1,  1, 2'd0, 12'h881, 2'b01, 4'h0, 0);
    vec[4]  = mkv(1, 2'd2, 2'b11, 4'h0, 2'd0, 12'h881, 2'b11,   0,  1, 2'd3, 12'h881, 2'b11, 4'h0, 0);
    vec[5]  = mkv(1, 2'd3, 2'b00, 4'h0, 2'd1, 12'h005, 2'b01,   0,  1, 2'd0, 12'h005, 2'b01, 4'h5, 0);
    vec[6]  = mkv(1, 2'd0, 2'b00, 4'h3, 2'd2, 12'h123, 2'b10,   0,  0, 2'd0, 12'h123, 2'b10, 4'h0, 0);
    vec[7]  = mkv(1, 2'd2, 2'b00, 4'h0, 2'd1, 12'h005, 2'b01,   1,  1, 2'd0, 12'h005, 2'b00, 4'h0, 0);
    vec[8]  = mkv(1, 2'd1, 2'b11, 4'h9, 2'd0, 12'h005, 2'b01,   1,  1, 2'd0, 12'hE45, 2'b11, 4'h0, 1);
    vec[9]  = mkv(1, 2'd1, 2'b10, 4'hF, 2'd2, 12'h8E2, 2'b11,   1,  1, 2'd1, 12'h8EF, 2'b11, 4'h0, 1);
    vec[10] = mkv(0, 2'd1, 2'b01, 4'h1, 2'd1, 12'h456, 2'b00,   0,  0, 2'd0, 12'h456, 2'b00, 4'h0, 1);
    vec[11] = mkv(1, 2'd1, 2'b00, 4'h4, 2'd3, 12'hE7F, 2'b10,   1,  1, 2'd0, 12'hE44, 2'b11, 4'h0, 2);
    vec[12] = mkv(1, 2'd3, 2'b11, 4'h0, 2'd0, 12'h005, 2'b01,   0,  1, 2'd3, 12'h005, 2'b01, 4'h0, 2);

    // ---- reset state ----
    reset  = 1'b0;
    clk_en = 1'b1;
    apply(1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 12'h000, 2'b00);
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      apply(vec[i].ov, vec[i].op, vec[i].key, vec[i].data, vec[i].adr, vec[i].content, vec[i].valid);
      tick();
      check_all($sformatf("vec%0d", i), vec[i].e, vec[i].ov, vec[i].adr, vec[i].occ);
    end
    occ_m = 2;

    // ---- clk_en=0 freezes everything for 3 cycles ----
    frozen = model(1'b1, 2'd1, 2'b10, 4'h6, 12'h000, 2'b00);
    apply(1'b1, 2'd1, 2'b10, 4'h6, 2'd2, 12'h000, 2'b00);
    tick();
    occ_m = clamp_occ(occ_m + frozen.occ_delta);
    check_all("freeze_issue", frozen, 1'b1, 2'd2, occ_m);
    clk_en = 1'b0;
    apply(1'b1, 2'd2, 2'b10, 4'h0, 2'd1, 12'h020, 2'b01);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all($sformatf("freeze_hold%0d", c), frozen, 1'b1, 2'd2, occ_m);
    end
    clk_en = 1'b1;
    apply(1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 12'h000, 2'b00);
    tick();

    // ---- occupancy saturates at all-ones ----
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 2'd1, 2'(i), 4'(i), 2'(i), 12'h000, 2'b00);
      tick();
      occ_m = clamp_occ(occ_m + 1);
    end
    check("occ_saturate_high", 32'(occupancy_o), 32'(OCC_MAX));
    check("occ_saturate_we", 32'(mem_we_o), 32'd1);
    apply(1'b1, 2'd2, 2'b01, 4'd0, 2'd0, 12'h010, 2'b01);
    tick();
    occ_m = clamp_occ(occ_m - 1);
    check("occ_after_sat_dec", 32'(occupancy_o), 32'(occ_m));

    // ---- randomized ops against the reference model ----
    for (int i = 0; i < 400; i++) begin
      logic        ov;
      logic [1:0]  op;
      logic [1:0]  key;
      logic [3:0]  data;
      logic [1:0]  adr;
      logic [11:0] content;
      logic [1:0]  valid;
      ov      = ($urandom_range(0, 7) != 0);
      op      = 2'($urandom_range(0, 3));
      key     = 2'($urandom);
      data    = 4'($urandom);
      adr     = 2'($urandom);
      content = 12'($urandom);
      valid   = 2'($urandom);
      e = model(ov, op, key, data, content, valid);
      apply(ov, op, key, data, adr, content, valid);
      tick();
      occ_m = clamp_occ(occ_m + e.occ_delta);
      check_all($sformatf("rnd%0d", i), e, ov, adr, occ_m);
    end

    // ---- reset during an INSERT ----
    apply(1'b1, 2'd1, 2'b10, 4'h3, 2'd2, 12'h000, 2'b00);
    @(posedge clk);
    #2;
    check("rst_mid_pre_we", 32'(mem_we_o), 32'd1);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    // An INSERT presented across an edge while reset is held is dropped too.
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 12'h000, 2'b00);
    tick();
    check("rst_drop_result_valid", 32'(result_valid_o), 32'd0);
    check("rst_drop_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_drop_occupancy", 32'(occupancy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bucket_writeback_unit
